// File: rtl/lsu_ctrl_if.sv
// Request, response and data-memory signal bundle for the lsu_ctrl load/store sequencer.
// The slave modport is the LSU's view; the master modport is the execute/memory environment.
interface lsu_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [4:0]            resp_rd;
    logic                  resp_exc;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wstrb;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_data, resp_rd, resp_exc,
        input  resp_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_data, resp_rd, resp_exc,
        output resp_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer between execute and a 64-bit data-memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise they are rounded down.
module lsu_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [4:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] respData_q, respData_d;
    logic                  respExc_q, respExc_d;

    logic [2:0]            reqAlignMask;
    logic                  reqIllegal;
    logic                  reqFault;
    logic [ADDR_WIDTH-1:0] reqEffAddr;

    logic [2:0]            laneOffset;
    logic [5:0]            laneShift;
    logic [7:0]            byteMask;
    logic [7:0]            storeStrb;
    logic [DATA_WIDTH-1:0] storeData;
    logic [DATA_WIDTH-1:0] loadLane;
    logic [DATA_WIDTH-1:0] loadExt;

    always_comb begin
        reqAlignMask = 3'b111;
        case (bus.req_funct3[1:0])
            2'b00:   reqAlignMask = 3'b000;
            2'b01:   reqAlignMask = 3'b001;
            2'b10:   reqAlignMask = 3'b011;
            default: reqAlignMask = 3'b111;
        endcase
    end

    assign reqIllegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);

`ifdef LSU_MISALIGN_TRAP_EN
    logic reqMisaligned;
    assign reqMisaligned = |(bus.req_addr[2:0] & reqAlignMask);
    assign reqFault      = reqIllegal | reqMisaligned;
    assign reqEffAddr    = bus.req_addr;
`else
    // Misaligned accesses silently round down to the natural boundary of their size.
    assign reqFault   = reqIllegal;
    assign reqEffAddr = {bus.req_addr[ADDR_WIDTH-1:3], bus.req_addr[2:0] & ~reqAlignMask};
`endif

    assign laneOffset = addr_q[2:0];
    assign laneShift  = {laneOffset, 3'b000};

    always_comb begin
        byteMask = 8'hFF;
        case (funct3_q[1:0])
            2'b00:   byteMask = 8'h01;
            2'b01:   byteMask = 8'h03;
            2'b10:   byteMask = 8'h0F;
            default: byteMask = 8'hFF;
        endcase
    end

    assign storeStrb = byteMask << laneOffset;
    assign storeData = wdata_q << laneShift;
    assign loadLane  = bus.mem_rdata >> laneShift;

    always_comb begin
        loadExt = loadLane;
        case (funct3_q)
            3'b000:  loadExt = {{(DATA_WIDTH-8){loadLane[7]}},   loadLane[7:0]};
            3'b001:  loadExt = {{(DATA_WIDTH-16){loadLane[15]}}, loadLane[15:0]};
            3'b010:  loadExt = {{(DATA_WIDTH-32){loadLane[31]}}, loadLane[31:0]};
            3'b100:  loadExt = {{(DATA_WIDTH-8){1'b0}},          loadLane[7:0]};
            3'b101:  loadExt = {{(DATA_WIDTH-16){1'b0}},         loadLane[15:0]};
            3'b110:  loadExt = {{(DATA_WIDTH-32){1'b0}},         loadLane[31:0]};
            default: loadExt = loadLane;
        endcase
    end

    // Faulting requests skip the bus entirely and report the original address.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        respData_d = respData_q;
        respExc_d  = respExc_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    funct3_d   = bus.req_funct3;
                    addr_d     = reqEffAddr;
                    wdata_d    = bus.req_wdata;
                    rd_d       = bus.req_rd;
                    respData_d = '0;
                    respExc_d  = 1'b0;
                    if (reqFault) begin
                        respData_d = DATA_WIDTH'(bus.req_addr);
                        respExc_d  = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    respData_d = we_q ? '0 : loadExt;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            respData_q <= '0;
            respExc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            respData_q <= respData_d;
            respExc_q  <= respExc_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign busy              = (state_q != IDLE);
    assign bus.mem_req_valid = (state_q == ISSUE);
    assign bus.mem_we        = (state_q == ISSUE) && we_q;
    assign bus.mem_wstrb     = ((state_q == ISSUE) && we_q) ? storeStrb : 8'h00;
    assign bus.mem_addr      = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    assign bus.mem_wdata     = storeData;
    assign bus.resp_valid    = (state_q == DONE);
    assign bus.resp_data     = respData_q;
    assign bus.resp_rd       = rd_q;
    assign bus.resp_exc      = (state_q == DONE) && respExc_q;

endmodule
